// File: rtl/zero_cross_freq_meter.sv
// Rising zero-crossing counter over a gate window of accepted audio samples, with hysteresis.
// Optional FREQ_AVG_EN: report the mean of the last four window counts instead of the raw count.
module zero_cross_freq_meter #(
   parameter int SAMPLE_W     = 24,
   parameter int COUNT_W      = 16,
   parameter int GATE_SAMPLES = 48000,
   parameter int HYST         = 0
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic                       sample_valid,
   input  logic                       start,
   input  logic                       continuous,
   output logic        [COUNT_W-1:0]  freq,
   output logic                       freq_valid,
   output logic                       busy,
   output logic                       overflow
);

   localparam int GATE_W = $clog2(GATE_SAMPLES + 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_SAMPLES - 1);
   localparam logic signed [SAMPLE_W-1:0] HYST_HI = SAMPLE_W'(HYST);
   localparam logic signed [SAMPLE_W-1:0] HYST_LO = SAMPLE_W'(-HYST);

   typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

   state_t              state, state_nx;
   logic [COUNT_W-1:0]  count, base_count, count_nx, inc_val;
   logic [GATE_W-1:0]   gate, base_gate;
   logic                sat, base_sat, sat_nx, inc_ovf;
   logic                armed;
   logic                is_low, is_high, accept, crossing, window_end;

   // Saturating increment; MSB of the result flags an attempt to pass full scale.
   function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] c);
      if (c == '1)
         return {1'b1, c};
      else
         return {1'b0, c + COUNT_W'(1)};
   endfunction

   always_comb begin
      is_low     = sample < HYST_LO;
      is_high    = sample >= HYST_HI;
      // DONE starts the next window from zero, so a sample accepted there counts fresh.
      base_count = (state == DONE) ? '0 : count;
      base_gate  = (state == DONE) ? '0 : gate;
      base_sat   = (state == DONE) ? 1'b0 : sat;
      accept     = sample_valid && !start &&
                   ((state == MEASURE) || ((state == DONE) && continuous));
      crossing   = accept && armed && is_high;
      {inc_ovf, inc_val} = sat_inc(base_count);
      count_nx   = crossing ? inc_val : base_count;
      sat_nx     = base_sat | (crossing & inc_ovf);
      window_end = accept && (base_gate == GATE_LAST);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = MEASURE;
         MEASURE: begin
            if (start)           state_nx = MEASURE;
            else if (window_end) state_nx = DONE;
         end
         DONE: begin
            if (start)           state_nx = MEASURE;
            else if (window_end) state_nx = DONE;
            else if (continuous) state_nx = MEASURE;
            else                 state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == MEASURE) || ((state == DONE) && continuous);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nx;
   end

`ifdef FREQ_AVG_EN
   logic [COUNT_W-1:0] hist [3];
   logic [2:0]         hist_ovf;
   logic [COUNT_W+1:0] sum;
   logic [COUNT_W-1:0] avg;

   always_comb begin
      sum = {2'b00, count_nx} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
      avg = sum[COUNT_W+1:2];
   end

   // History survives start; only reset clears it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hist[0]  <= '0;
         hist[1]  <= '0;
         hist[2]  <= '0;
         hist_ovf <= '0;
      end else if (window_end) begin
         hist[0]  <= count_nx;
         hist[1]  <= hist[0];
         hist[2]  <= hist[1];
         hist_ovf <= {hist_ovf[1:0], sat_nx};
      end
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count      <= '0;
         gate       <= '0;
         sat        <= 1'b0;
         armed      <= 1'b0;
         freq       <= '0;
         freq_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         freq_valid <= 1'b0;
         if (start) begin
            count <= '0;
            gate  <= '0;
            sat   <= 1'b0;
            armed <= 1'b0;
         end else begin
            if (accept) begin
               count <= count_nx;
               gate  <= base_gate + GATE_W'(1);
               sat   <= sat_nx;
               if (is_low)       armed <= 1'b1;
               else if (is_high) armed <= 1'b0;
            end else if (state == DONE) begin
               count <= '0;
               gate  <= '0;
               sat   <= 1'b0;
            end
            if (window_end) begin
               freq_valid <= 1'b1;
`ifdef FREQ_AVG_EN
               freq       <= avg;
               overflow   <= sat_nx | (|hist_ovf);
`else
               freq       <= count_nx;
               overflow   <= sat_nx;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_zero_cross_freq_meter.sv
// Directed bench for zero_cross_freq_meter: three instances (plain, hysteresis, narrow counter) share stimulus.
module tb_zero_cross_freq_meter;

   localparam int SW   = 24;
   localparam int GATE = 48;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic signed [SW-1:0] sample;
   logic                 sample_valid, start, continuous;

   logic [15:0] freq0, freq1;
   logic [2:0]  freq2;
   logic        fv0, busy0, ovf0, fv1, busy1, ovf1, fv2, busy2, ovf2;

   int checks = 0;
   int errors = 0;

   zero_cross_freq_meter #(.SAMPLE_W(SW), .COUNT_W(16), .GATE_SAMPLES(GATE), .HYST(0)) dut0 (
      .clk(clk), .resetn(resetn), .sample(sample), .sample_valid(sample_valid), .start(start),
      .continuous(continuous), .freq(freq0), .freq_valid(fv0), .busy(busy0), .overflow(ovf0));

   zero_cross_freq_meter #(.SAMPLE_W(SW), .COUNT_W(16), .GATE_SAMPLES(GATE), .HYST(100)) dut1 (
      .clk(clk), .resetn(resetn), .sample(sample), .sample_valid(sample_valid), .start(start),
      .continuous(continuous), .freq(freq1), .freq_valid(fv1), .busy(busy1), .overflow(ovf1));

   zero_cross_freq_meter #(.SAMPLE_W(SW), .COUNT_W(3), .GATE_SAMPLES(GATE), .HYST(0)) dut2 (
      .clk(clk), .resetn(resetn), .sample(sample), .sample_valid(sample_valid), .start(start),
      .continuous(continuous), .freq(freq2), .freq_valid(fv2), .busy(busy2), .overflow(ovf2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pulse monitor for dut0: counts freq_valid pulses, records freq, watches busy.
   int          fv_cnt0 = 0;
   logic [15:0] rec0[$];
   bit          mon_busy = 1'b0;
   int          busy_drops = 0;

   always @(negedge clk) begin
      if (fv0 === 1'b1) begin
         fv_cnt0++;
         rec0.push_back(freq0);
      end
      if (mon_busy && busy0 !== 1'b1) busy_drops++;
   end

   function automatic logic signed [SW-1:0] wave(input int mode, input int i);
      int v;
      case (mode)
         0:       v = (i % 8 < 4) ? -1000 : 1000;
         1:       v = (i % 2 == 0) ? 50 : -50;
         2:       v = (i % 4 < 2) ? -500 : 500;
         3:       v = (i % 2 == 0) ? -1 : 1;
         default: v = (i % 6 < 3) ? -1000 : 1000;
      endcase
      return SW'(v);
   endfunction

   // Returns on the falling edge right after the final sample is accepted.
   task automatic feed(input int n, input int mode, input int gap, input int off);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample       = wave(mode, i + off);
         sample_valid = 1'b1;
         if (gap > 1) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (i < n - 1) repeat (gap - 2) @(negedge clk);
         end
      end
      if (gap == 1) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int exp_avg[4];
      resetn       = 1'b0;
      sample       = '0;
      sample_valid = 1'b0;
      start        = 1'b0;
      continuous   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_freq", 32'(freq0), 0);
      check("rst_fv", 32'(fv0), 0);
      check("rst_busy", 32'(busy0), 0);
      check("rst_ovf", 32'(ovf0), 0);
      resetn = 1'b1;
      @(negedge clk);

      // Square wave, one sample every 4 clocks
      pulse_start();
      check("t1_busy_on", 32'(busy0), 1);
      base = fv_cnt0;
      feed(GATE, 0, 4, 0);
      #1;
      check("t1_fv", 32'(fv0), 1);
      check("t1_freq", 32'(freq0), 6);
      check("t1_busy_off", 32'(busy0), 0);
      check("t1_ovf", 32'(ovf0), 0);
      check("t1_pulses", 32'(fv_cnt0 - base), 1);
      check("t1_hyst_freq", 32'(freq1), 6);
      @(negedge clk);
      #1;
      check("t1_fv_single", 32'(fv0), 0);

      // Hysteresis dead band, then a wave that clears it
      pulse_start();
      feed(GATE, 1, 1, 0);
      #1;
      check("t2_dead_fv", 32'(fv1), 1);
      check("t2_dead_freq", 32'(freq1), 0);
      pulse_start();
      feed(GATE, 2, 1, 0);
      #1;
      check("t2_hyst_freq", 32'(freq1), 12);
      check("t2_plain_freq", 32'(freq0), 12);

      // Saturation of a 3-bit counter, then clearing on a clean window
      pulse_start();
      feed(GATE, 3, 1, 0);
      #1;
      check("t3_sat_freq", 32'(freq2), 7);
      check("t3_sat_ovf", 32'(ovf2), 1);
      check("t3_wide_freq", 32'(freq0), 24);
      check("t3_wide_ovf", 32'(ovf0), 0);
      pulse_start();
      feed(GATE, 0, 1, 0);
      #1;
      check("t3_clr_freq", 32'(freq2), 6);
      check("t3_clr_ovf", 32'(ovf2), 0);

      // Continuous mode over three back-to-back windows
      continuous = 1'b1;
      base = rec0.size();
      pulse_start();
      mon_busy = 1'b1;
      feed(3 * GATE, 0, 1, 2);
      #1;
      check("t4_busy_end", 32'(busy0), 1);
      mon_busy = 1'b0;
      check("t4_busy_drops", 32'(busy_drops), 0);
      check("t4_pulses", 32'(rec0.size() - base), 3);
      for (int k = 0; k < 3; k++)
         if (rec0.size() > base + k) check($sformatf("t4_freq%0d", k), 32'(rec0[base + k]), 6);
      continuous = 1'b0;
      @(negedge clk);
      #1;
      check("t4_idle", 32'(busy0), 0);

      // Restart mid-window; the colliding sample is discarded
      pulse_start();
      feed(20, 0, 1, 0);
      #1;
      base = fv_cnt0;
      @(negedge clk);
      start        = 1'b1;
      sample       = wave(0, 0);
      sample_valid = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      sample_valid = 1'b0;
      feed(GATE - 1, 0, 1, 0);
      #1;
      check("t5_no_early", 32'(fv_cnt0 - base), 0);
      check("t5_busy", 32'(busy0), 1);
      feed(1, 0, 1, GATE - 1);
      #1;
      check("t5_fv", 32'(fv0), 1);
      check("t5_freq", 32'(freq0), 6);
      check("t5_pulses", 32'(fv_cnt0 - base), 1);

      // Asynchronous reset in the middle of a window
      pulse_start();
      feed(10, 0, 1, 0);
      #2;
      resetn = 1'b0;
      #1;
      check("t6_freq", 32'(freq0), 0);
      check("t6_busy", 32'(busy0), 0);
      check("t6_fv", 32'(fv0), 0);
      check("t6_ovf", 32'(ovf0), 0);
      check("t6_freq_hyst", 32'(freq1), 0);
      check("t6_freq_narrow", 32'(freq2), 0);
      @(negedge clk);
      resetn = 1'b1;

      // Windows of 8, 8, 8 and 12 crossings
`ifdef FREQ_AVG_EN
      exp_avg = '{2, 4, 6, 9};
`else
      exp_avg = '{8, 8, 8, 12};
`endif
      for (int k = 0; k < 4; k++) begin
         pulse_start();
         feed(GATE, (k == 3) ? 2 : 4, 1, 0);
         #1;
         check($sformatf("t7_freq%0d", k), 32'(freq0), 32'(exp_avg[k]));
      end
      check("t7_ovf", 32'(ovf0), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
